// File: rtl/mem_responder.sv
// Wait-stated 2^ADDR_BITS x 32 memory responder: MAR/MDR-style CPU interface,
// IDLE/WAIT/DONE transaction FSM with snapshot-at-accept semantics.
module mem_responder #(
  parameter int ADDR_BITS   = 9,
  parameter int WAIT_STATES = 2
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        MARin,
  input  logic [31:0] BusMuxOut,
  input  logic [31:0] MDataOut,
  input  logic        Read,
  input  logic        Write,
  output logic [31:0] MDataIn,
  output logic        Busy,
  output logic        Done,
  output logic        Err
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  localparam logic [3:0] LAST = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  logic [31:0]          mem [0:(2**ADDR_BITS)-1];
  state_t               state, state_next;
  logic [3:0]           count;
  logic [ADDR_BITS-1:0] mar, addr_snap, acc_addr;
  logic                 oor;
  logic [31:0]          data_snap, acc_data;
  logic                 rd_snap, reject_snap, acc_rd, acc_reject;
  logic                 accept, access;

  assign accept = (state == S_IDLE) && (Read || Write);

  // With zero wait states the access happens on the accept edge itself, so it
  // must see the live request rather than the (not yet loaded) snapshot.
  assign acc_addr   = (state == S_IDLE) ? mar : addr_snap;
  assign acc_data   = (state == S_IDLE) ? MDataOut : data_snap;
  assign acc_rd     = (state == S_IDLE) ? Read : rd_snap;
  assign acc_reject = (state == S_IDLE) ? ((Read && Write) || oor) : reject_snap;

  assign access = (accept && (WAIT_STATES == 0)) ||
                  ((state == S_WAIT) && (count == LAST));

  // NOTE: every variable driven here gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE: if (accept) state_next = (WAIT_STATES == 0) ? S_DONE : S_WAIT;
      S_WAIT: if (count == LAST) state_next = S_DONE;
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update from the same pre-edge values.
  always_ff @(posedge clock) begin
    if (clear) begin
      state       <= S_IDLE;
      count       <= '0;
      mar         <= '0;
      oor         <= 1'b0;
      MDataIn     <= '0;
      addr_snap   <= '0;
      data_snap   <= '0;
      rd_snap     <= 1'b0;
      reject_snap <= 1'b0;
    end else begin
      state <= state_next;
      if (MARin) begin
        mar <= BusMuxOut[ADDR_BITS-1:0];
        oor <= |BusMuxOut[31:ADDR_BITS];
      end
      if (accept) begin
        addr_snap   <= mar;
        data_snap   <= MDataOut;
        rd_snap     <= Read;
        reject_snap <= (Read && Write) || oor;
        count       <= '0;
      end else if (state == S_WAIT) begin
        count <= count + 4'd1;
      end
      if (access && !acc_reject && acc_rd)
        MDataIn <= mem[acc_addr];
    end
  end

  // NOTE: the storage array has no reset; clear only blocks a pending write.
  always_ff @(posedge clock) begin
    if (!clear && access && !acc_reject && !acc_rd)
      mem[acc_addr] <= acc_data;
  end

  assign Busy = (state != S_IDLE);
  assign Done = (state == S_DONE);
  assign Err  = Done && reject_snap;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a table of transactions on a 2-wait-state
// instance plus hand sequences for snapshot, abort and zero-wait streaming.
module tb_mem_responder;

  localparam int W = 2;

  logic        clock = 1'b0;
  logic        clear = 1'b1;
  logic        MARin = 1'b0, Read = 1'b0, Write = 1'b0;
  logic [31:0] BusMuxOut = '0, MDataOut = '0;
  logic [31:0] MDataIn;
  logic        Busy, Done, Err;

  logic        z_MARin = 1'b0, z_Read = 1'b0, z_Write = 1'b0;
  logic [31:0] z_bus = '0, z_wdata = '0;
  logic [31:0] z_MDataIn;
  logic        z_Busy, z_Done, z_Err;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  mem_responder #(.ADDR_BITS(9), .WAIT_STATES(W)) dut (
    .clock(clock), .clear(clear), .MARin(MARin), .BusMuxOut(BusMuxOut),
    .MDataOut(MDataOut), .Read(Read), .Write(Write), .MDataIn(MDataIn),
    .Busy(Busy), .Done(Done), .Err(Err)
  );

  mem_responder #(.ADDR_BITS(9), .WAIT_STATES(0)) dut0 (
    .clock(clock), .clear(clear), .MARin(z_MARin), .BusMuxOut(z_bus),
    .MDataOut(z_wdata), .Read(z_Read), .Write(z_Write), .MDataIn(z_MDataIn),
    .Busy(z_Busy), .Done(z_Done), .Err(z_Err)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic        err;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic load_mar(input logic [31:0] addr);
    MARin = 1'b1;
    BusMuxOut = addr;
    step();
    MARin = 1'b0;
    BusMuxOut = '0;
  endtask

  // Full transaction on the W-wait-state instance with latency and result checks.
  task automatic xact(input string name, input logic rd, input logic wr,
                      input logic [31:0] addr, input logic [31:0] data,
                      input logic exp_err, input logic [31:0] exp_rdata);
    int n;
    load_mar(addr);
    Read = rd;
    Write = wr;
    MDataOut = data;
    step();
    Read = 1'b0;
    Write = 1'b0;
    MDataOut = '0;
    n = 0;
    while (!Done && n < 8) begin
      check({name, "_busy"}, 32'(Busy), 32'd1);
      step();
      n++;
    end
    check({name, "_latency"}, n, W);
    check({name, "_done"}, 32'(Done), 32'd1);
    check({name, "_err"}, 32'(Err), 32'(exp_err));
    check({name, "_rdata"}, MDataIn, exp_rdata);
    step();
    check({name, "_idle"}, {30'd0, Busy, Done}, 32'd0);
  endtask

  task automatic z_write(input logic [31:0] addr, input logic [31:0] data);
    z_MARin = 1'b1;
    z_bus = addr;
    step();
    z_MARin = 1'b0;
    z_Write = 1'b1;
    z_wdata = data;
    step();
    check("w0_write_done", {30'd0, z_Done, z_Err}, 32'd2);
    z_Write = 1'b0;
    step();
  endtask

  initial begin
    int pulses;

    vecs[0]  = '{1'b0, 1'b1, 32'h010,      32'hDEADBEEF, 1'b0, 32'h00000000};
    vecs[1]  = '{1'b1, 1'b0, 32'h010,      32'h0,        1'b0, 32'hDEADBEEF};
    vecs[2]  = '{1'b0, 1'b1, 32'h005,      32'h00001234, 1'b0, 32'hDEADBEEF};
    vecs[3]  = '{1'b1, 1'b0, 32'h200,      32'h0,        1'b1, 32'hDEADBEEF};
    vecs[4]  = '{1'b1, 1'b1, 32'h005,      32'hFFFFFFFF, 1'b1, 32'hDEADBEEF};
    vecs[5]  = '{1'b1, 1'b0, 32'h005,      32'h0,        1'b0, 32'h00001234};
    vecs[6]  = '{1'b0, 1'b1, 32'h000,      32'h11111111, 1'b0, 32'h00001234};
    vecs[7]  = '{1'b0, 1'b1, 32'h200,      32'h22222222, 1'b1, 32'h00001234};
    vecs[8]  = '{1'b1, 1'b0, 32'h000,      32'h0,        1'b0, 32'h11111111};
    vecs[9]  = '{1'b0, 1'b1, 32'h1FF,      32'h55AA55AA, 1'b0, 32'h11111111};
    vecs[10] = '{1'b1, 1'b0, 32'h1FF,      32'h0,        1'b0, 32'h55AA55AA};
    vecs[11] = '{1'b0, 1'b1, 32'h80000003, 32'h33333333, 1'b1, 32'h55AA55AA};
    vecs[12] = '{1'b0, 1'b1, 32'h007,      32'h77777777, 1'b0, 32'h55AA55AA};
    vecs[13] = '{1'b0, 1'b1, 32'h009,      32'h99999999, 1'b0, 32'h55AA55AA};

    step();
    step();
    clear = 1'b0;
    check("reset_outputs", {29'd0, Busy, Done, Err}, 32'd0);
    check("reset_mdatain", MDataIn, 32'd0);

    for (int i = 0; i < 14; i++)
      xact($sformatf("vec%0d", i), vecs[i].rd, vecs[i].wr, vecs[i].addr,
           vecs[i].data, vecs[i].err, vecs[i].rdata);

    // Address and data change during WAIT must not redirect the write.
    load_mar(32'h3);
    Write = 1'b1;
    MDataOut = 32'hA5A5A5A5;
    step();
    Write = 1'b0;
    MARin = 1'b1;
    BusMuxOut = 32'h7;
    MDataOut = 32'h0;
    step();
    MARin = 1'b0;
    BusMuxOut = '0;
    step();
    check("snap_done", {30'd0, Done, Err}, 32'd2);
    step();
    xact("snap_rd3", 1'b1, 1'b0, 32'h3, 32'h0, 1'b0, 32'hA5A5A5A5);
    xact("snap_rd7", 1'b1, 1'b0, 32'h7, 32'h0, 1'b0, 32'h77777777);

    // Clear one cycle after accept aborts the write with no Done pulse.
    load_mar(32'h9);
    Write = 1'b1;
    MDataOut = 32'hCAFEF00D;
    step();
    Write = 1'b0;
    MDataOut = '0;
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("abort_outputs", {29'd0, Busy, Done, Err}, 32'd0);
    check("abort_mdatain", MDataIn, 32'd0);
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (Done) pulses++;
    end
    check("abort_no_done", pulses, 0);
    xact("abort_rd9", 1'b1, 1'b0, 32'h9, 32'h0, 1'b0, 32'h99999999);

    // Zero wait states: held Read streams a result every other cycle.
    z_write(32'h1, 32'h0000AAAA);
    z_write(32'h2, 32'h0000BBBB);
    z_MARin = 1'b1;
    z_bus = 32'h1;
    step();
    z_MARin = 1'b0;
    z_Read = 1'b1;
    step();
    check("w0_done_a", {30'd0, z_Done, z_Err}, 32'd2);
    check("w0_data_a", z_MDataIn, 32'h0000AAAA);
    z_MARin = 1'b1;
    z_bus = 32'h2;
    step();
    z_MARin = 1'b0;
    check("w0_gap", {30'd0, z_Busy, z_Done}, 32'd0);
    step();
    check("w0_done_b", {30'd0, z_Done, z_Err}, 32'd2);
    check("w0_data_b", z_MDataIn, 32'h0000BBBB);
    z_Read = 1'b0;
    step();
    check("w0_idle", {30'd0, z_Busy, z_Done}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
